// File: rtl/irq_ctrl_if.sv
// Register-window bus between the CPU glue logic and irq_ctrl.
// Carries the select, direction, strobe, address and data signals of one access.
// master = CPU/bus side; slave = irq_ctrl. No backpressure: every strobed access completes.
interface irq_ctrl_if;
  logic       cs_n;      // register-window select, active-low
  logic       rw;        // 1 = read, 0 = write
  logic       strobe;    // one clock per access; writes commit on this clock
  logic [2:0] addr;      // register index
  logic [7:0] data_in;   // write data
  logic [7:0] data_out;  // read data, combinational from addr
  logic       data_oe;   // high while a read of the window is in progress

  modport master (
    output cs_n, rw, strobe, addr, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  cs_n, rw, strobe, addr, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller for the 6502 IRQB line: sync, latch (level/edge), mask, fixed priority.
// Latency: source low at edge k -> PEND at k+2 -> irq_n low at k+3; ACK at w -> irq_n high at w+1.
// No backpressure: every strobed register access completes in its clock; reads are side-effect free.
// Ports: clock/reset (async, active-high); src_n[7:0] active-low sources (bit 0 highest priority);
//        bus (irq_ctrl_if.slave) register window; irq_n registered active-low request to the CPU.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  src_n,
  irq_ctrl_if.slave   bus,
  output logic        irq_n
);

  localparam logic [2:0] A_RAW    = 3'd0;
  localparam logic [2:0] A_PEND   = 3'd1;
  localparam logic [2:0] A_ENABLE = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_ACT    = 3'd4;
  localparam logic [2:0] A_VECTOR = 3'd5;
  localparam logic [2:0] A_FORCE  = 3'd6;

  // Bits at N_SRC and above are tied off everywhere through this mask.
  localparam logic [8:0] SRC_ONES = (9'd1 << N_SRC) - 9'd1;
  localparam logic [7:0] SRC_MASK = SRC_ONES[7:0];

  logic [7:0] s1, s2, s3;
  logic [7:0] pend_q, enable_q, edge_q;
  logic [7:0] pend_nxt;
  logic [7:0] edge_evt;
  logic [7:0] ack_wr, force_wr, mode_chg;
  logic [7:0] act;
  logic [7:0] vector;
  logic [2:0] vec_idx;
  logic       wr;

  assign wr       = ~bus.cs_n & ~bus.rw & bus.strobe;
  assign ack_wr   = (wr && bus.addr == A_PEND)  ? (bus.data_in & SRC_MASK) : 8'h00;
  assign force_wr = (wr && bus.addr == A_FORCE) ? (bus.data_in & SRC_MASK) : 8'h00;
  // Bits whose mode flips on an EDGE write start over from a clean PEND.
  assign mode_chg = (wr && bus.addr == A_EDGE)
                    ? ((bus.data_in & SRC_MASK) ^ edge_q) : 8'h00;

  assign edge_evt = s2 & ~s3;
  assign act      = pend_q & enable_q;

  // Synchroniser: inverted so 1 = asserted from here on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 8'h00;
      s2 <= 8'h00;
      s3 <= 8'h00;
    end else begin
      s1 <= ~src_n & SRC_MASK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Edge bits: a new edge beats a simultaneous ACK so no event is lost.
  always_comb begin
    pend_nxt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (mode_chg[i])
        pend_nxt[i] = 1'b0;
      else if (edge_q[i])
        pend_nxt[i] = edge_evt[i] | force_wr[i] | (pend_q[i] & ~ack_wr[i]);
      else
        pend_nxt[i] = s2[i];
    end
    pend_nxt = pend_nxt & SRC_MASK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q   <= 8'h00;
      enable_q <= 8'h00;
      edge_q   <= 8'h00;
      irq_n    <= 1'b1;
    end else begin
      pend_q <= pend_nxt;
      irq_n  <= ~|act;
      if (wr && bus.addr == A_ENABLE)
        enable_q <= bus.data_in & SRC_MASK;
      if (wr && bus.addr == A_EDGE)
        edge_q <= bus.data_in & SRC_MASK;
    end
  end

  // Fixed priority: scan downwards so the lowest active index is left standing.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i])
        vec_idx = 3'(i);
    end
  end

  assign vector = (|act) ? {1'b1, 4'b0000, vec_idx} : 8'h00;

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.addr)
      A_RAW:    bus.data_out = s2;
      A_PEND:   bus.data_out = pend_q;
      A_ENABLE: bus.data_out = enable_q;
      A_EDGE:   bus.data_out = edge_q;
      A_ACT:    bus.data_out = act;
      A_VECTOR: bus.data_out = vector;
      default:  bus.data_out = 8'h00;
    endcase
  end

  assign bus.data_oe = ~bus.cs_n & bus.rw;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected values queued at stimulus time, popped at observation.
// Timing: inputs driven 1ns after the rising edge, outputs sampled after a further settle delay.
// Covers level/edge latching, W1C, FORCE, priority, masking, collisions and async reset.
`timescale 1ns/1ps
module tb_irq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] src_n;
  logic       irq_n;

  irq_ctrl_if bus();

  irq_ctrl #(.N_SRC(8)) dut (
    .clock (clock),
    .reset (reset),
    .src_n (src_n),
    .bus   (bus),
    .irq_n (irq_n)
  );

  always #50 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  string      sb_tag[$];
  logic [7:0] sb_exp[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop_check(input logic [7:0] obs);
    if (sb_exp.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got 0x%02h, expected an entry", obs);
    end else begin
      check(sb_tag.pop_front(), obs, sb_exp.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus.cs_n    = 1'b0;
    bus.rw      = 1'b0;
    bus.strobe  = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    tick(1);
    bus.strobe  = 1'b0;
    bus.cs_n    = 1'b1;
    bus.rw      = 1'b1;
  endtask

  task automatic expect_reg(input logic [2:0] a, input logic [7:0] exp, input string tag);
    sb_push(tag, exp);
    bus.addr = a;
    bus.cs_n = 1'b0;
    bus.rw   = 1'b1;
    #1;
    sb_pop_check(bus.data_out);
    bus.cs_n = 1'b1;
  endtask

  task automatic expect_irq(input logic exp, input string tag);
    sb_push(tag, {7'b0, exp});
    #1;
    sb_pop_check({7'b0, irq_n});
  endtask

  initial begin
    reset       = 1'b1;
    src_n       = 8'hFF;
    bus.cs_n    = 1'b1;
    bus.rw      = 1'b1;
    bus.strobe  = 1'b0;
    bus.addr    = 3'd0;
    bus.data_in = 8'h00;
    #2;
    expect_irq(1'b1, "reset_irq_n");
    for (int a = 0; a < 8; a++) expect_reg(3'(a), 8'h00, $sformatf("reset_reg%0d", a));
    #10 reset = 1'b0;
    tick(2);

    // Level source 1, enabled.
    bus_write(3'd2, 8'h02);
    src_n = 8'hFD;
    tick(1); expect_reg(3'd1, 8'h00, "lvl_pend_k");
    tick(1); expect_reg(3'd1, 8'h00, "lvl_pend_k1");
             expect_reg(3'd0, 8'h02, "lvl_raw_k1");
    tick(1); expect_reg(3'd1, 8'h02, "lvl_pend_k2");
             expect_irq(1'b1, "lvl_irq_k2");
    tick(1); expect_irq(1'b0, "lvl_irq_k3");
             expect_reg(3'd5, 8'h81, "lvl_vector");
             expect_reg(3'd4, 8'h02, "lvl_act");
    src_n = 8'hFF;
    tick(3); expect_reg(3'd1, 8'h00, "lvl_rel_pend");
             expect_irq(1'b0, "lvl_rel_irq_k2");
    tick(1); expect_irq(1'b1, "lvl_rel_irq_k3");

    // Edge latch on source 0, then W1C.
    bus_write(3'd3, 8'h01);
    bus_write(3'd2, 8'h01);
    src_n = 8'hFE;
    tick(2);
    src_n = 8'hFF;
    tick(5); expect_reg(3'd1, 8'h01, "edge_pend_held");
             expect_irq(1'b0, "edge_irq");
    bus_write(3'd1, 8'h01);
    expect_reg(3'd1, 8'h00, "w1c_pend");
    expect_irq(1'b0, "w1c_irq_same");
    tick(1); expect_irq(1'b1, "w1c_irq_next");

    // Priority between level sources 3 and 6.
    bus_write(3'd3, 8'h00);
    bus_write(3'd2, 8'hFF);
    src_n = 8'hB7;
    tick(3); expect_reg(3'd5, 8'h83, "prio_vec_3_6");
             expect_reg(3'd1, 8'h48, "prio_pend");
    src_n = 8'hBF;
    tick(3); expect_reg(3'd5, 8'h86, "prio_vec_6");
    src_n = 8'hFF;
    tick(4); expect_irq(1'b1, "prio_idle_irq");
             expect_reg(3'd5, 8'h00, "prio_idle_vec");

    // Mask.
    bus_write(3'd2, 8'h00);
    src_n = 8'hEF;
    tick(3); expect_reg(3'd1, 8'h10, "mask_pend");
             expect_reg(3'd4, 8'h00, "mask_act");
    tick(1); expect_irq(1'b1, "mask_irq");
    bus_write(3'd2, 8'h10);
    expect_irq(1'b1, "unmask_irq_same");
    tick(1); expect_irq(1'b0, "unmask_irq_next");
    src_n = 8'hFF;
    tick(4); expect_irq(1'b1, "unmask_rel_irq");

    // FORCE and edge/ACK collision on bit 2; FORCE on bit 7 in both modes.
    bus_write(3'd3, 8'h84);
    bus_write(3'd2, 8'h84);
    bus_write(3'd6, 8'h04);
    expect_reg(3'd1, 8'h04, "force_bit2");
    expect_reg(3'd6, 8'h00, "force_reads0");
    src_n = 8'hFB;
    tick(2);
    bus_write(3'd1, 8'h04);
    expect_reg(3'd1, 8'h04, "collision_set_wins");
    bus_write(3'd1, 8'h04);
    expect_reg(3'd1, 8'h00, "collision_then_ack");
    src_n = 8'hFF;
    tick(3); expect_reg(3'd1, 8'h00, "edge_rise_ignored");
    bus_write(3'd6, 8'h80);
    expect_reg(3'd1, 8'h80, "force_edge7");
    bus_write(3'd1, 8'h80);
    bus_write(3'd3, 8'h04);
    expect_reg(3'd3, 8'h04, "edge_reg");
    bus_write(3'd6, 8'h80);
    expect_reg(3'd1, 8'h00, "force_level7_ignored");

    // Async reset with irq_n asserted.
    bus_write(3'd6, 8'h04);
    tick(1); expect_irq(1'b0, "pre_reset_irq");
    #10 reset = 1'b1;
    expect_irq(1'b1, "async_reset_irq");
    for (int a = 0; a < 8; a++) expect_reg(3'(a), 8'h00, $sformatf("async_reset_reg%0d", a));

    // Release reset with a level source held low.
    src_n = 8'hFD;
    #5 reset = 1'b0;
    tick(1); expect_reg(3'd0, 8'h00, "rst_hold_raw1");
    tick(1); expect_reg(3'd0, 8'h02, "rst_hold_raw2");
    tick(1); expect_reg(3'd1, 8'h02, "rst_hold_pend");
    src_n = 8'hFF;
    tick(4);

    // Register 7, writes without strobe or select.
    bus_write(3'd7, 8'hFF);
    expect_reg(3'd7, 8'h00, "reg7_read");
    bus.cs_n = 1'b0; bus.rw = 1'b0; bus.strobe = 1'b0;
    bus.addr = 3'd2; bus.data_in = 8'hFF;
    #1;
    check("data_oe_write", {7'b0, bus.data_oe}, 8'h00);
    tick(1);
    bus.cs_n = 1'b1; bus.strobe = 1'b1;
    tick(1);
    bus.strobe = 1'b0; bus.rw = 1'b1;
    expect_reg(3'd2, 8'h00, "no_strobe_no_cs_write");
    bus.cs_n = 1'b0;
    #1;
    check("data_oe_read", {7'b0, bus.data_oe}, 8'h01);
    bus.cs_n = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller for the 6502 IRQB line. Replaces the hard-wired AND of VIA/UART interrupt outputs.
- Synchronises up to eight active-low interrupt sources. Latches them per source as either level or falling-edge requests, masks them, and resolves a fixed priority.
- Drives a single active-low irq_n to the CPU.
- Software reaches it through a register window inside the bifrost chip-select region, using a one-clock access strobe.

Parameters:
- N_SRC, 8, number of interrupt sources in use (1..8). Source bits at index N_SRC and above read 0 and are never pending.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_n  input  8  interrupt sources, active-low, asynchronous to clock. Bit 0 has the highest priority.
- cs_n  input  1  register-window select, active-low.
- rw  input  1  1 = read, 0 = write.
- strobe  input  1  high for exactly one clock per bus access; writes take effect only on that clock.
- addr  input  3  register index.
- data_in  input  8  write data.
- data_out  output  8  read data, combinational from addr.
- data_oe  output  1  equals ~cs_n & rw; the top level uses it to drive the data bus.
- irq_n  output  1  registered, active-low interrupt request to the CPU.

Behaviour:
- Reset values: all registers 0x00, synchroniser flops 0 (deasserted), irq_n = 1.
- Synchroniser: a = ~src_n. s1 <= a, s2 <= s1, s3 <= s2. Edge event e = s2 & ~s3.
- Pending update, per bit i, each clock:
  - Level mode (EDGE[i] = 0): PEND[i] <= s2[i]. W1C and FORCE writes are ignored for the bit.
  - Edge mode (EDGE[i] = 1): PEND[i] <= e[i] | FORCE_wr[i] | (PEND[i] & ~ACK_wr[i]).
  - An edge and an ACK on the same bit in the same clock: set wins, so no event is lost.
- ACT = PEND & ENABLE. irq_n <= ~|ACT, registered.
- Latency: a source low at sampling edge k sets PEND at edge k+2 and drives irq_n low at edge k+3.
  - Deassertion in level mode follows the same 3-clock latency.
  - An ACK write at edge w clears PEND at w and raises irq_n at w+1, unless other bits are still active.
- Register map (addr):
  - 0 RAW (R): s2 (1 = asserted).
  - 1 PEND (R); W: write-1-to-clear, edge-mode bits only.
  - 2 ENABLE (R/W).
  - 3 EDGE (R/W): 1 = falling-edge mode. Any bit whose mode changes on the write has PEND cleared that clock; level bits then reload from s2 on the next clock.
  - 4 ACT (R).
  - 5 VECTOR (R): bit7 = |ACT; bits 2:0 = lowest index set in ACT; bits 6:3 = 0. Reads 0x00 when nothing is active.
  - 6 FORCE (W): write-1 sets PEND for edge-mode bits; level-mode bits are unaffected. Reads 0x00.
  - 7: reads 0x00, writes ignored.
- Reads have no side effects; repeated read cycles are safe.
- A write requires ~cs_n & ~rw & strobe.
- Reset released while a source is held low:
  - Level mode: the source appears after 2 clocks.
  - Edge mode: EDGE is 0 out of reset, so no spurious edge latches; edges count only after software sets EDGE.
- Reset asserted mid-operation: asynchronously clears everything and forces irq_n = 1 immediately.

Test Plan:
- Level source: ENABLE = 0x02, src_n[1] low at edge 10 → PEND = 0x02 at edge 12, irq_n = 0 at edge 13, VECTOR = 0x81. Release src_n[1] → irq_n = 1 three clocks later; PEND = 0x00.
- Edge latch and W1C: EDGE = 0x01, ENABLE = 0x01, 2-clock low pulse on src_n[0] → PEND = 0x01 persists after the pulse. Write PEND = 0x01 → PEND = 0x00, irq_n = 1 next clock.
- Priority: ENABLE = 0xFF, sources 3 and 6 asserted in level mode → VECTOR = 0x83. Release 3 → VECTOR = 0x86.
- Mask: source 4 asserted, ENABLE = 0x00 → PEND = 0x10, ACT = 0x00, irq_n = 1. Write ENABLE = 0x10 → irq_n = 0 on the following clock.
- Collision and FORCE:
  - Edge on bit 2 at the same clock as a W1C write of 0x04 → PEND[2] stays 1.
  - FORCE 0x80 with EDGE[7] = 1 → PEND = 0x80.
  - FORCE 0x80 with EDGE[7] = 0 → no change.
- Reset: assert reset with irq_n = 0 → irq_n = 1 and all registers 0x00 without a clock edge. Register 7 reads 0x00; writes without strobe are ignored.
